// File: rtl/loanio_gpio_ctrl.sv
// Loan-IO GPIO controller: debounced inputs with edge events and a sticky irq,
// plus per-channel OFF/STATIC/BLINK/PWM outputs. Define LOANIO_ACTIVE_LOW_EN to invert pin_out.

module loanio_deb #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic state,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          state_q, state_d, rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      state_d = sync2_q;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

module loanio_out_ch #(
  parameter int   PWM_BITS = 8,
  parameter logic INV      = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [PWM_BITS+1:0] wr_data,
  input  logic [PWM_BITS-1:0] pwm_nxt,
  input  logic                blink_nxt,
  output logic                pin_out,
  output logic                pin_oe
);
  typedef enum logic [1:0] {M_OFF, M_STATIC, M_BLINK, M_PWM} mode_e;

  mode_e               mode_q, mode_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                out_q, out_d, oe_q, oe_d, lvl;

  always_comb begin
    mode_d = mode_q;
    duty_d = duty_q;
    if (wr_en) begin
      mode_d = mode_e'(wr_data[PWM_BITS+1:PWM_BITS]);
      duty_d = wr_data[PWM_BITS-1:0];
    end
    lvl  = 1'b0;
    oe_d = 1'b1;
    // Counters' next values keep pin_out phase-aligned with the live counters.
    case (mode_q)
      M_OFF:    oe_d = 1'b0;
      M_STATIC: lvl  = duty_q[0];
      M_BLINK:  lvl  = blink_nxt;
      M_PWM:    lvl  = (pwm_nxt < duty_q);
      default:  oe_d = 1'b0;
    endcase
    out_d = lvl ^ INV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= M_OFF;
      duty_q <= '0;
      out_q  <= INV;
      oe_q   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      duty_q <= duty_d;
      out_q  <= out_d;
      oe_q   <= oe_d;
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = oe_q;
endmodule

module loanio_gpio_ctrl #(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 24,
  localparam int AW        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IN-1:0]     pin_in,
  output logic [N_IN-1:0]     in_state,
  output logic [N_IN-1:0]     in_rise,
  output logic [N_IN-1:0]     in_fall,
  output logic                irq,
  input  logic                irq_ack,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [PWM_BITS+1:0] cfg_data,
  output logic [N_OUT-1:0]    pin_out,
  output logic [N_OUT-1:0]    pin_oe,
  output logic                heartbeat
);
`ifdef LOANIO_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic [N_IN-1:0]       evt_q, evt_d;
  logic                  irq_q, irq_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    loanio_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .pin   (pin_in[i]),
      .state (in_state[i]),
      .rise  (in_rise[i]),
      .fall  (in_fall[i])
    );
  end

  // A fresh edge beats a coincident ack so no event is lost.
  always_comb begin
    evt_d       = (evt_q & ~{N_IN{irq_ack}}) | in_rise | in_fall;
    irq_d       = |evt_d;
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q       <= '0;
      irq_q       <= 1'b0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
    end else begin
      evt_q       <= evt_d;
      irq_q       <= irq_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    loanio_out_ch #(.PWM_BITS(PWM_BITS), .INV(INV)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (cfg_we && (cfg_addr == AW'(j))),
      .wr_data   (cfg_data),
      .pwm_nxt   (reset ? '0 : pwm_cnt_d),
      .blink_nxt (reset ? 1'b0 : blink_cnt_d[BLINK_BITS-1]),
      .pin_out   (pin_out[j]),
      .pin_oe    (pin_oe[j])
    );
  end

  assign irq       = irq_q;
  assign heartbeat = blink_cnt_q[BLINK_BITS-1];
endmodule
